// File: rtl/rv_dmem_resp.sv
// rtl/rv_dmem_resp.sv - data-port responder: word RAM plus GPIO/timer/compare/status MMIO block
// Optional build macro RV_DMEM_ERR_EN adds a sticky bus_err_o for unmapped or malformed accesses.
module rv_dmem_resp #(
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE = 32'h0001_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic [31:0] gpio_o,
    output logic        timer_irq_o
`ifdef RV_DMEM_ERR_EN
    ,
    output logic        bus_err_o
`endif
);

    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0]   mem [MEM_WORDS];
    logic [31:0]   mtime;
    logic [31:0]   mtimecmp;
    logic [AW-1:0] idx;
    logic          is_ram;
    logic          is_mmio;
    logic          sel_gpio;
    logic          sel_mtime;
    logic          sel_cmp;
    logic          sel_status;
    logic          unused_addr;

    assign idx         = data_addr_i[AW+1:2];
    assign is_ram      = (data_addr_i[31:16] == 16'h0000);
    assign is_mmio     = (data_addr_i[31:16] == MMIO_BASE[31:16]) && (data_addr_i[15:4] == 12'h000);
    assign sel_gpio    = is_mmio && (data_addr_i[3:2] == 2'd0);
    assign sel_mtime   = is_mmio && (data_addr_i[3:2] == 2'd1);
    assign sel_cmp     = is_mmio && (data_addr_i[3:2] == 2'd2);
    assign sel_status  = is_mmio && (data_addr_i[3:2] == 2'd3);
    assign unused_addr = ^data_addr_i[1:0];

    // Loads complete in the same cycle; a same-cycle write is not forwarded.
    always_comb begin
        data_rdata_o = 32'h0;
        if (is_ram)
            data_rdata_o = mem[idx];
        else if (sel_gpio)
            data_rdata_o = gpio_o;
        else if (sel_mtime)
            data_rdata_o = mtime;
        else if (sel_cmp)
            data_rdata_o = mtimecmp;
        else if (sel_status)
            data_rdata_o = {31'h0, timer_irq_o};
    end

    // RAM has no reset; gating on rst_ni drops a store that coincides with reset.
    always_ff @(posedge clk_i) begin
        if (rst_ni && data_we_i && is_ram)
            mem[idx] <= data_wdata_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gpio_o      <= 32'h0;
            mtime       <= 32'h0;
            mtimecmp    <= 32'hFFFF_FFFF;
            timer_irq_o <= 1'b0;
        end else begin
            if (data_we_i && sel_gpio)
                gpio_o <= data_wdata_i;
            if (data_we_i && sel_mtime)
                mtime <= data_wdata_i;
            else
                mtime <= mtime + 32'd1;
            if (data_we_i && sel_cmp)
                mtimecmp <= data_wdata_i;
            // A match in the same cycle as a clear keeps the interrupt pending.
            if (mtime == mtimecmp)
                timer_irq_o <= 1'b1;
            else if (data_we_i && sel_status && data_wdata_i[0])
                timer_irq_o <= 1'b0;
        end
    end

`ifdef RV_DMEM_ERR_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            bus_err_o <= 1'b0;
        else if (!(is_ram || is_mmio) || (data_we_i && sel_status && (data_wdata_i[31:1] != 31'h0)))
            bus_err_o <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_rv_dmem_resp.sv
// tb/tb_rv_dmem_resp.sv - self-checking bench for rv_dmem_resp: vector table, timer sequences, random traffic vs model
module tb_rv_dmem_resp;

    localparam int          MEM_WORDS = 1024;
    localparam logic [31:0] MMIO_BASE = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] data_addr_i = 32'h0;
    logic        data_we_i = 1'b0;
    logic [31:0] data_wdata_i = 32'h0;
    logic [31:0] data_rdata_o;
    logic [31:0] gpio_o;
    logic        timer_irq_o;
`ifdef RV_DMEM_ERR_EN
    logic        bus_err_o;
`endif

    int checks = 0;
    int errors = 0;

    rv_dmem_resp #(.MEM_WORDS(MEM_WORDS), .MMIO_BASE(MMIO_BASE)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .data_addr_i  (data_addr_i),
        .data_we_i    (data_we_i),
        .data_wdata_i (data_wdata_i),
        .data_rdata_o (data_rdata_o),
        .gpio_o       (gpio_o),
        .timer_irq_o  (timer_irq_o)
`ifdef RV_DMEM_ERR_EN
        ,
        .bus_err_o    (bus_err_o)
`endif
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_mem [int];
    logic [31:0] m_gpio;
    logic [31:0] m_mtime;
    logic [31:0] m_cmp;
    logic        m_irq;
    logic        m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_gpio  = 32'h0;
        m_mtime = 32'h0;
        m_cmp   = 32'hFFFF_FFFF;
        m_irq   = 1'b0;
        m_err   = 1'b0;
    endtask

    function automatic bit in_ram(input logic [31:0] a);
        return a[31:16] == 16'h0;
    endfunction

    function automatic bit in_mmio(input logic [31:0] a);
        return (a[31:16] == MMIO_BASE[31:16]) && (a[15:4] == 12'h0);
    endfunction

    task automatic model_read(input logic [31:0] a, output logic [31:0] v, output bit known);
        int w;
        known = 1'b1;
        v = 32'h0;
        if (in_ram(a)) begin
            w = int'((a >> 2) % MEM_WORDS);
            if (m_mem.exists(w)) v = m_mem[w];
            else known = 1'b0;
        end else if (in_mmio(a)) begin
            case (a[3:2])
                2'd0: v = m_gpio;
                2'd1: v = m_mtime;
                2'd2: v = m_cmp;
                default: v = {31'h0, m_irq};
            endcase
        end
    endtask

    task automatic model_edge(input logic [31:0] a, input logic w, input logic [31:0] d);
        logic [31:0] n_mtime;
        logic [31:0] n_cmp;
        logic        n_irq;
        n_mtime = m_mtime + 32'd1;
        n_cmp   = m_cmp;
        n_irq   = m_irq;
        if (!(in_ram(a) || in_mmio(a))) m_err = 1'b1;
        if (w && in_ram(a)) m_mem[int'((a >> 2) % MEM_WORDS)] = d;
        if (w && in_mmio(a)) begin
            case (a[3:2])
                2'd0: m_gpio = d;
                2'd1: n_mtime = d;
                2'd2: n_cmp = d;
                default: begin
                    if (d[0]) n_irq = 1'b0;
                    if (d[31:1] != 31'h0) m_err = 1'b1;
                end
            endcase
        end
        if (m_mtime == m_cmp) n_irq = 1'b1;
        m_mtime = n_mtime;
        m_cmp   = n_cmp;
        m_irq   = n_irq;
    endtask

    // One bus cycle: entered just after a falling edge, leaves just after the next one.
    task automatic step(input logic [31:0] a, input logic w, input logic [31:0] d, output logic [31:0] rd);
        logic [31:0] ev;
        bit known;
        data_addr_i  = a;
        data_we_i    = w;
        data_wdata_i = d;
        #1;
        rd = data_rdata_o;
        model_read(a, ev, known);
        if (known) chk("rdata", rd, ev);
        @(posedge clk);
        model_edge(a, w, d);
        #1;
        chk("gpio", gpio_o, m_gpio);
        chk("irq", {31'h0, timer_irq_o}, {31'h0, m_irq});
`ifdef RV_DMEM_ERR_EN
        chk("bus_err", {31'h0, bus_err_o}, {31'h0, m_err});
`endif
        @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] gpio;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [31:0] rd;
        logic [31:0] r32;
        logic [31:0] a;
        int sel;
        bit found;

        tbl[0] = '{32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 32'h1000_0004, 32'h0};
        tbl[1] = '{32'h0000_0010, 1'b0, 32'h0,         32'hDEAD_BEEF, 32'h0};
        tbl[2] = '{32'h0000_1010, 1'b0, 32'h0,         32'hDEAD_BEEF, 32'h0};
        tbl[3] = '{MMIO_BASE,     1'b1, 32'h0000_00A5, 32'h0,         32'hA5};
        tbl[4] = '{MMIO_BASE,     1'b0, 32'h0,         32'h0000_00A5, 32'hA5};
        tbl[5] = '{MMIO_BASE + 32'h20, 1'b0, 32'h0,    32'h0,         32'hA5};
        tbl[6] = '{32'h0002_0000, 1'b1, 32'h1234_5678, 32'h0,         32'hA5};
        tbl[7] = '{MMIO_BASE + 32'h8, 1'b0, 32'h0,     32'hFFFF_FFFF, 32'hA5};
        tbl[8] = '{32'h8000_0000, 1'b0, 32'h0,         32'h0,         32'hA5};
        tbl[9] = '{MMIO_BASE + 32'hC, 1'b0, 32'h0,     32'h0,         32'hA5};

        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_gpio", gpio_o, 32'h0);
        chk("reset_irq", {31'h0, timer_irq_o}, 32'h0);
        rst_ni = 1'b1;

        for (int i = 0; i < MEM_WORDS; i++)
            step(32'(i * 4), 1'b1, 32'h1000_0000 + 32'(i), rd);

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].addr, tbl[i].we, tbl[i].wdata, rd);
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].rdata);
            chk($sformatf("vec%0d_gpio", i), gpio_o, tbl[i].gpio);
        end

        // Timer compare: irq rises one edge after mtime reads 110
        step(MMIO_BASE + 32'h4, 1'b1, 32'd100, rd);
        step(MMIO_BASE + 32'h8, 1'b1, 32'd110, rd);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(MMIO_BASE + 32'h4, 1'b0, 32'h0, rd);
            if (rd == 32'd109) chk("irq_before_match", {31'h0, timer_irq_o}, 32'h0);
            if (rd == 32'd110) begin
                found = 1'b1;
                chk("irq_rise", {31'h0, timer_irq_o}, 32'h1);
            end
        end
        chk("match_found", {31'h0, found}, 32'h1);
        for (int i = 0; i < 3; i++) step(MMIO_BASE + 32'hC, 1'b0, 32'h0, rd);
        chk("irq_sticky", rd, 32'h1);
        step(MMIO_BASE + 32'hC, 1'b1, 32'h0, rd);
        chk("status_w0_noop", {31'h0, timer_irq_o}, 32'h1);
        step(MMIO_BASE + 32'hC, 1'b1, 32'h1, rd);
        chk("status_clear", {31'h0, timer_irq_o}, 32'h0);

        // Clear lands exactly on the match cycle
        step(MMIO_BASE + 32'h8, 1'b1, m_mtime + 32'd3, rd);
        step(MMIO_BASE + 32'h4, 1'b0, 32'h0, rd);
        step(MMIO_BASE + 32'h4, 1'b0, 32'h0, rd);
        chk("irq_pre_simul", {31'h0, timer_irq_o}, 32'h0);
        step(MMIO_BASE + 32'hC, 1'b1, 32'h1, rd);
        chk("set_wins", {31'h0, timer_irq_o}, 32'h1);

        // Wrap
        step(MMIO_BASE + 32'h4, 1'b1, 32'hFFFF_FFFE, rd);
        step(MMIO_BASE + 32'h4, 1'b0, 32'h0, rd);
        chk("wrap_fe", rd, 32'hFFFF_FFFE);
        step(MMIO_BASE + 32'h4, 1'b0, 32'h0, rd);
        chk("wrap_ff", rd, 32'hFFFF_FFFF);
        step(MMIO_BASE + 32'h4, 1'b0, 32'h0, rd);
        chk("wrap_00", rd, 32'h0);

        // Asynchronous reset mid-cycle with a pending GPIO write dropped
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_gpio", gpio_o, 32'h0);
        chk("async_irq", {31'h0, timer_irq_o}, 32'h0);
        data_addr_i = MMIO_BASE + 32'h8;
        data_we_i   = 1'b0;
        #1;
        chk("reset_cmp", data_rdata_o, 32'hFFFF_FFFF);
        data_addr_i  = MMIO_BASE;
        data_we_i    = 1'b1;
        data_wdata_i = 32'h77;
        @(posedge clk);
        #1;
        chk("reset_drop_write", gpio_o, 32'h0);
        model_reset();
        @(negedge clk);
        data_we_i = 1'b0;
        rst_ni = 1'b1;
        step(32'h0000_0010, 1'b0, 32'h0, rd);
        chk("ram_kept", rd, 32'hDEAD_BEEF);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 9);
            r32 = $urandom;
            case (sel)
                0, 1, 2, 3: a = {16'h0, r32[15:0]};
                4, 5, 6:    a = MMIO_BASE | {28'h0, r32[3:0]};
                7:          a = MMIO_BASE | {16'h0, r32[15:4] | 12'h001, r32[3:0]};
                8:          a = r32;
                default:    a = MMIO_BASE + 32'h8;
            endcase
            r32 = $urandom;
            if (sel == 9) r32 = m_mtime + 32'($urandom_range(1, 5));
            else if (sel == 5 && $urandom_range(0, 1) == 1) r32 = 32'h1;
            step(a, 1'($urandom_range(0, 1)), r32, rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rv_dmem_resp.md
Name: rv_dmem_resp

Overview:
Data-memory responder for the single-cycle core's data port, i.e. the target end of the core's data_addr/data_we/data_o/data_i interface.
- Word-addressed RAM plus a small MMIO block: GPIO output register, free-running timer, timer compare, sticky interrupt status.
- Reads are combinational, so a load completes in the same cycle. Writes commit on the clock edge.
- Sits beside the core in the top level. No handshake: every cycle is a valid access.

Parameters:
MEM_WORDS, 1024, RAM depth in 32-bit words (power of two, >=4)
MMIO_BASE, 32'h0001_0000, base byte address of MMIO block (64 KiB aligned)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset
data_addr_i  in  32  byte address from core (ALU result)
data_we_i  in  1  write enable (store)
data_wdata_i  in  32  store data
data_rdata_o  out  32  load data, combinational from data_addr_i
gpio_o  out  32  GPIO output register
timer_irq_o  out  1  sticky timer-compare interrupt

Behaviour:
Reset and clocking:
- One clock, clk_i. Reset rst_ni is asynchronous and active-low.
- Reset values: gpio_o=0, mtime=0, mtimecmp=32'hFFFF_FFFF, timer_irq_o=0.
- RAM contents are not reset.
- data_rdata_o is purely combinational, so it has no reset value of its own.

Address decode (addr[1:0] ignored; all accesses are full words):
- RAM region: addr[31:16]==0.
  - Index is addr[$clog2(MEM_WORDS)+1:2].
  - Upper bits within the region are ignored, so addresses alias and wrap modulo MEM_WORDS.
- MMIO region: addr[31:16]==MMIO_BASE[31:16]. Offset is addr[3:0]; addr[15:4] must be 0, otherwise unmapped.
  - 0x0 GPIO: RW.
  - 0x4 MTIME: read returns the current value. A write loads the counter.
  - 0x8 MTIMECMP: RW.
  - 0xC STATUS: bit0 is irq pending, other bits read 0. Writing 1 to bit0 clears it; writing 0 has no effect.
- Unmapped addresses: reads return 32'h0, writes are ignored.

Reads:
- Combinational, zero latency. They have no side effects.
- The core presents an address every cycle, including non-load cycles.

Writes:
- Take effect at the rising clk_i edge when data_we_i=1. The new value is visible to reads in the next cycle.
- A read of the same address in the write cycle returns the old value.

Timer:
- mtime increments by 1 every cycle and wraps 32'hFFFF_FFFF -> 0.
- A write to MTIME loads data_wdata_i, overriding the increment that cycle. Counting resumes from the loaded value next cycle.
- When mtime==mtimecmp (compared on the registered value), timer_irq_o sets at the next edge and stays set.
- If a STATUS clear and a compare match occur in the same cycle, set wins.
- A write to MTIMECMP takes effect for the comparison starting next cycle.

Reset mid-operation:
- All registers return to reset values immediately, asynchronously.
- A write pending in that cycle is dropped.

Optional Feature:
RV_DMEM_ERR_EN
- Defined: adds output port bus_err_o (1 bit, reset 0).
  - Sets at the edge after any write to an unmapped address, or to STATUS with bits[31:1] nonzero.
  - Sets at the edge after any read of an unmapped address.
  - Sticky until reset.
- Not defined: the port does not exist and unmapped accesses are silent.
- Address decode and read data are identical in both builds.

Test Plan:
- Reset: assert rst_ni=0 mid-cycle -> gpio_o=0, timer_irq_o=0 immediately. Read MMIO_BASE+0x8 returns 32'hFFFF_FFFF.
- RAM write/read and alias: write 32'hDEADBEEF to 0x0000_0010; next cycle read 0x10 -> 32'hDEADBEEF. With MEM_WORDS=1024, read 0x0000_1010 -> 32'hDEADBEEF. Same-cycle read of 0x10 returns the old value.
- GPIO and unmapped: write 32'h0000_00A5 to MMIO_BASE -> gpio_o=32'hA5 next cycle. Read MMIO_BASE+0x20 -> 0. Write to 0x0002_0000 -> no state change.
- Timer compare: write MTIME=100, then MTIMECMP=110 -> timer_irq_o rises exactly one edge after mtime reads 110 and stays high. Write STATUS=1 -> cleared. Read MTIME wraps after loading 32'hFFFF_FFFE.
- Simultaneous set/clear: time the STATUS=1 write to the match cycle -> timer_irq_o remains 1.
- RV_DMEM_ERR_EN build: read 0x8000_0000 -> bus_err_o=1 next cycle and stays 1. In the non-macro build, the same stimulus returns data 0.
